// File: rtl/fetch_unit.sv
// Instruction-fetch front end: next-PC generation, credit-limited memory request link,
// in-order prefetch queue and a flush FSM that discards responses made stale by a redirect.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [1:0]            redirect_type,
    input  logic [ADDR_WIDTH-1:0] redirect_base,
    input  logic [15:0]           redirect_imm16,
    input  logic [25:0]           redirect_addr26,
    input  logic [ADDR_WIDTH-1:0] redirect_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(QUEUE_DEPTH);

    typedef enum logic {ST_FETCH, ST_FLUSH} state_t;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_n;
    logic [ADDR_WIDTH-1:0] seq_pc, target;
    logic                  req_valid_q, req_valid_n;
    logic [PTR_W-1:0]      q_head, q_tail, pf_head, pf_tail;
    logic [CNT_W-1:0]      q_count, q_count_n, outstanding, outstanding_n;
    logic                  redirect_take, req_fire, resp_take, push, pop;

    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pf_pc  [QUEUE_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect_take = redirect_valid && (redirect_type != 2'b00);
    assign req_fire      = req_valid_q && imem_req_ready;
    // A response with nothing outstanding has no request to pair with and is ignored.
    assign resp_take     = imem_resp_valid && (outstanding != '0);
    assign push          = resp_take && (state_q == ST_FETCH) && !redirect_take;
    assign pop           = out_valid && out_ready;

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = (q_count != '0);
    assign out_instr      = out_valid ? q_data[q_head] : '0;
    assign out_pc         = out_valid ? q_pc[q_head]   : '0;

    always_comb begin
        seq_pc = redirect_base + ADDR_WIDTH'(4);
        case (redirect_type)
            2'b01:   target = seq_pc + {{(ADDR_WIDTH-18){redirect_imm16[15]}}, redirect_imm16, 2'b00};
            2'b10:   target = {seq_pc[ADDR_WIDTH-1:28], redirect_addr26, 2'b00};
            2'b11:   target = {redirect_reg[ADDR_WIDTH-1:2], 2'b00};
            default: target = fetch_pc_q;
        endcase
    end

    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        outstanding_n = outstanding + CNT_W'(req_fire) - CNT_W'(resp_take);
        q_count_n     = redirect_take ? '0 : q_count + CNT_W'(push) - CNT_W'(pop);

        fetch_pc_n = fetch_pc_q;
        if (redirect_take)
            fetch_pc_n = target;
        else if (req_fire)
            fetch_pc_n = fetch_pc_q + ADDR_WIDTH'(4);

        state_n = state_q;
        if (redirect_take)
            state_n = (outstanding_n != '0) ? ST_FLUSH : ST_FETCH;
        else if ((state_q == ST_FLUSH) && (outstanding_n == '0))
            state_n = ST_FETCH;

        // Credit is judged on next-cycle counts so the request valid can be a plain register.
        req_valid_n = (state_n == ST_FETCH) &&
                      (({1'b0, q_count_n} + {1'b0, outstanding_n}) < DEPTH_W);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
            outstanding <= '0;
        end else begin
            state_q     <= state_n;
            fetch_pc_q  <= fetch_pc_n;
            req_valid_q <= req_valid_n;
            q_count     <= q_count_n;
            outstanding <= outstanding_n;
            if (redirect_take) begin
                q_head <= '0;
                q_tail <= '0;
            end else begin
                if (pop)  q_head <= ptr_inc(q_head);
                if (push) q_tail <= ptr_inc(q_tail);
            end
            if (req_fire)  pf_tail <= ptr_inc(pf_tail);
            if (resp_take) pf_head <= ptr_inc(pf_head);
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts above decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[q_tail] <= imem_resp_data;
            q_pc[q_tail]   <= pf_pc[pf_head];
        end
        if (req_fire)
            pf_pc[pf_tail] <= fetch_pc_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit: a memory model, an epoch-based reference
// model of which responses survive redirects, and a monitor that scoreboards every handshake.
module tb_fetch_unit;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req_valid, imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          redirect_valid;
    logic [1:0]    redirect_type;
    logic [AW-1:0] redirect_base, redirect_reg;
    logic [15:0]   redirect_imm16;
    logic [25:0]   redirect_addr26;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_type(redirect_type), .redirect_base(redirect_base),
        .redirect_imm16(redirect_imm16), .redirect_addr26(redirect_addr26), .redirect_reg(redirect_reg),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    int          tests = 0, fails = 0;
    int          epoch = 0, cyc = 0, last_due = 0, since_rst = 0, acc_since_rst = 0;
    int          first_acc_cyc = -1, first_ov_cyc = -1;
    logic [31:0] exp_req_pc = RST_PC;
    bit          rand_mode = 1'b0, fix_ready = 1'b1, fix_out_ready = 1'b1;
    int          lat_fix = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no event within cycle budget (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] t, input logic [31:0] base,
                                                 input logic [15:0] imm, input logic [25:0] a26,
                                                 input logic [31:0] rg);
        int off;
        off = int'($signed(imm));
        case (t)
            2'b01:   return base + 32'd4 + 32'(off * 4);
            2'b10:   return ((base + 32'd4) & 32'hF000_0000) | (32'(a26) << 2);
            default: return rg & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Memory and handshake driver.
    initial begin
        imem_req_ready = 1'b0; out_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        forever begin
            @(negedge clk); #1;
            if (rand_mode) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                out_ready      = ($urandom_range(0, 3) != 0);
            end else begin
                imem_req_ready = fix_ready;
                out_ready      = fix_out_ready;
            end
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(mem_q[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // Monitor: evaluates what the coming clock edge will do and updates the reference model.
    initial begin : monitor
        mem_req_t r;
        logic [31:0] pc;
        bit old, redir;
        int due, lat;
        forever begin
            @(negedge clk); #3;
            if (!reset) begin
                since_rst = 0;
                acc_since_rst = 0;
                continue;
            end
            check("out_valid", out_valid, exp_q.size() != 0);
            if (since_rst >= 1) begin
                old = 1'b0;
                foreach (mem_q[i]) if (mem_q[i].epoch != epoch) old = 1'b1;
                check("req_valid", imem_req_valid, !old && (exp_q.size() + mem_q.size() < DEPTH));
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            redir = redirect_valid && (redirect_type != 2'b00);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_model", {63'b0, out_valid}, 64'd0);
                end else begin
                    pc = exp_q.pop_front();
                    check("out_pc", out_pc, pc);
                    check("out_instr", out_instr, instr_of(pc));
                end
            end
            if (imem_resp_valid && mem_q.size() > 0) begin
                r = mem_q.pop_front();
                if (r.epoch == epoch && !redir) exp_q.push_back(r.addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_req_pc);
                lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{imem_req_addr, due, epoch});
                exp_req_pc = exp_req_pc + 32'd4;
                acc_since_rst++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (redir) begin
                epoch++;
                exp_q.delete();
                exp_req_pc = model_target(redirect_type, redirect_base, redirect_imm16,
                                          redirect_addr26, redirect_reg);
            end
            cyc++;
            since_rst++;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        mem_q.delete();
        exp_q.delete();
        epoch = 0; last_due = 0; exp_req_pc = RST_PC;
        first_acc_cyc = -1; first_ov_cyc = -1;
        run(2); #2;
        reset = 1'b1;
    endtask

    task automatic redirect(input logic [1:0] t, input logic [31:0] base, input logic [15:0] imm,
                            input logic [25:0] a26, input logic [31:0] rg, input bit coincide);
        int k;
        @(negedge clk); #2;
        if (coincide) begin
            k = 0;
            while (!(imem_resp_valid && out_valid && out_ready) && k < 100) begin
                @(negedge clk); #2;
                k++;
            end
            check("coincidence_found", k < 100, 1);
        end
        redirect_valid = 1'b1; redirect_type = t; redirect_base = base;
        redirect_imm16 = imm; redirect_addr26 = a26; redirect_reg = rg;
        @(negedge clk); #2;
        redirect_valid = 1'b0; redirect_type = 2'b00;
        check("out_valid_after_redirect", out_valid, 0);
    endtask

    task automatic wait_pop(input logic [31:0] exp, input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #4;
            if (out_valid && out_ready) begin
                check(name, out_pc, exp);
                return;
            end
        end
        timeout(name);
    endtask

    task automatic wait_req(input logic [31:0] exp, input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #4;
            if (imem_req_valid && imem_req_ready) begin
                check(name, imem_req_addr, exp);
                return;
            end
        end
        timeout(name);
    endtask

    task automatic wait_inflight(input int n, input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #4;
            if (mem_q.size() >= n) return;
        end
        timeout(name);
    endtask

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_type = 2'b00; redirect_base = '0;
        redirect_imm16 = '0; redirect_addr26 = '0; redirect_reg = '0;

        // Streaming from reset with a one-cycle memory.
        apply_reset();
        run(12);
        check("first_out_latency", first_ov_cyc - first_acc_cyc, 2);

        // Decode stalled: credits run out after a full queue's worth of requests.
        fix_out_ready = 1'b0;
        apply_reset();
        run(12);
        check("stalled_req_count", acc_since_rst, DEPTH);
        check("stalled_req_valid", imem_req_valid, 0);
        check("stalled_req_addr", imem_req_addr, 32'h10);
        fix_out_ready = 1'b1;
        wait_req(32'h10, "resume_req_addr");

        // Backward branch with two requests in flight.
        lat_fix = 6;
        apply_reset();
        wait_inflight(2, "two_inflight");
        fix_ready = 1'b0;
        redirect(2'b01, 32'h100, 16'hFFFE, '0, '0, 1'b0);
        fix_ready = 1'b1;
        wait_pop(32'hFC, "branch_first_pc");

        // Jump keeps the upper nibble of base+4; register target drops misaligned bits.
        lat_fix = 1;
        redirect(2'b10, 32'h3000_0010, '0, 26'h40, '0, 1'b0);
        wait_req(32'h3000_0100, "jump_req_addr");
        wait_pop(32'h3000_0100, "jump_first_pc");
        redirect(2'b11, '0, '0, '0, 32'h203, 1'b0);
        wait_req(32'h200, "reg_req_addr");
        wait_pop(32'h200, "reg_first_pc");

        // Redirect landing on the same edge as a response and a pop.
        run(6);
        redirect(2'b11, '0, '0, '0, 32'h4000, 1'b1);
        wait_pop(32'h4000, "coincide_first_pc");

        // Address wrap, then reset while requests are in flight.
        redirect(2'b11, '0, '0, '0, 32'hFFFF_FFFF, 1'b0);
        wait_req(32'hFFFF_FFFC, "top_req_addr");
        wait_req(32'h0, "wrap_req_addr");
        lat_fix = 8;
        wait_inflight(3, "three_inflight");
        apply_reset();

        // Random traffic with random redirects, including ignored type 00.
        rand_mode = 1'b1;
        lat_fix = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid  = 1'b1;
                redirect_type   = 2'($urandom_range(0, 3));
                redirect_base   = $urandom;
                redirect_imm16  = 16'($urandom);
                redirect_addr26 = 26'($urandom);
                redirect_reg    = $urandom;
            end else begin
                redirect_valid = 1'b0;
                redirect_type  = 2'b00;
            end
        end
        @(negedge clk); #2;
        redirect_valid = 1'b0;
        redirect_type  = 2'b00;
        rand_mode = 1'b0; fix_ready = 1'b0; fix_out_ready = 1'b1;
        begin : drain
            for (int k = 0; k < 200; k++) begin
                @(negedge clk); #4;
                if (mem_q.size() == 0 && exp_q.size() == 0) disable drain;
            end
            timeout("drain");
        end
        run(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
